// File: rtl/powlib_strmchk_pkg.sv
// Shared definitions for the stream checker: state encodings and LFSR constants.
package powlib_strmchk_pkg;

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } strmchk_state_e;

    localparam int unsigned    LFSR_W    = 16;
    localparam logic [15:0]    LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as a mask over state[15:0]
    localparam logic [15:0]    LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/powlib_lfsr.sv
// Fibonacci LFSR; shifts toward the MSB with the XOR of the tapped bits fed into bit 0.
module powlib_lfsr
    import powlib_strmchk_pkg::*;
#(
    parameter int unsigned          width = LFSR_W,
    parameter logic [width-1:0]     taps  = LFSR_TAPS,
    parameter logic [width-1:0]     seed  = LFSR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [width-1:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= seed;
        end else if (en) begin
            state <= {state[width-2:0], ^(state & taps)};
        end
    end

endmodule

// File: rtl/powlib_strmchk.sv
// Incrementing-sequence stream checker: seeds on the first beat, then counts beats and mismatches.
// Define POWLIB_STRMCHK_BP_EN to add LFSR-driven pseudo-random backpressure on rdrdy.
module powlib_strmchk
    import powlib_strmchk_pkg::*;
#(
    parameter int unsigned W           = 32,
    parameter int unsigned CW          = 32,
    parameter bit          STOP_ON_ERR = 1'b0,
    parameter              ID          = "STRMCHK"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [W-1:0]  rddata,
    input  logic          rdvld,
    output logic          rdrdy,
    output logic          err,
    output logic [CW-1:0] errcnt,
    output logic [CW-1:0] wordcnt,
    output logic          halted
);

    // ID only labels the instance; reject nonsensical configurations at elaboration
    if (W < 1 || CW < 1 || $bits(ID) < 8) begin : g_param_check
        $error("powlib_strmchk: invalid parameters");
    end

    strmchk_state_e state, state_n;
    logic [W-1:0]   exp;
    logic           bp_ok;
    logic           accept;
    logic           mismatch;

`ifdef POWLIB_STRMCHK_BP_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_unused;

    powlib_lfsr #(
        .width (LFSR_W),
        .taps  (LFSR_TAPS),
        .seed  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr_q)
    );

    assign bp_ok       = (lfsr_q[1:0] != 2'b00);
    assign lfsr_unused = ^lfsr_q[LFSR_W-1:2];
`else
    assign bp_ok = 1'b1;
`endif

    // Ready is gated by reset and clr directly so neither can ever admit a beat
    assign rdrdy    = rst & ~clr & (state != HALT) & bp_ok;
    assign accept   = rdvld & rdrdy;
    assign mismatch = (rddata != exp);
    assign halted   = (state == HALT);

    always_comb begin
        state_n = state;
        unique case (state)
            SEED:    if (accept) state_n = CHECK;
            CHECK:   if (accept && mismatch && STOP_ON_ERR) state_n = HALT;
            HALT:    state_n = HALT;
            default: state_n = SEED;
        endcase
        if (clr) state_n = SEED;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp     <= '0;
            err     <= 1'b0;
            errcnt  <= '0;
            wordcnt <= '0;
        end else if (clr) begin
            exp     <= '0;
            err     <= 1'b0;
            errcnt  <= '0;
            wordcnt <= '0;
        end else if (accept) begin
            // Expectation always follows the received data, so a mismatch resyncs
            exp <= rddata + W'(1);
            if (state == SEED) begin
                wordcnt <= CW'(1);
            end else begin
                if (wordcnt != '1) wordcnt <= wordcnt + CW'(1);
                if (mismatch) begin
                    err <= 1'b1;
                    if (errcnt != '1) errcnt <= errcnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/powlib_strmchk.md
POWLIB_STRMCHK -- requirements
Module: powlib_strmchk

Interface
REQ-001 Parameter W, default 32, data width in bits.
REQ-002 Parameter CW, default 32, width of beat and error counters.
REQ-003 Parameter STOP_ON_ERR, default 0, 1 = halt consumption on first mismatch.
REQ-004 Parameter ID, default "STRMCHK", instance label for simulation messages only.
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous clear of checker state and counters.
REQ-008 rddata  input  W  stream data from FIFO read side.
REQ-009 rdvld  input  1  stream valid.
REQ-010 rdrdy  output  1  stream ready (this block consumes).
REQ-011 err  output  1  sticky mismatch flag.
REQ-012 errcnt  output  CW  number of mismatched beats.
REQ-013 wordcnt  output  CW  number of accepted beats.
REQ-014 halted  output  1  high while in HALT state.

Function
REQ-015 Beat accepted SHALL mean rdvld & rdrdy at a rising edge; no other condition consumes data.
REQ-016 States SHALL be SEED, CHECK, HALT; reset and clr enter SEED.
REQ-017 SEED: first accepted beat loads exp = rddata+1 (mod 2^W), wordcnt=1, no comparison, next state CHECK.
REQ-018 CHECK: accepted beat compared to exp; match -> exp = rddata+1; mismatch -> err=1, errcnt+1, exp = rddata+1 (resync).
REQ-019 CHECK mismatch with STOP_ON_ERR=1 SHALL go to HALT; HALT holds rdrdy=0 until rst or clr.
REQ-020 exp wrap from all-ones to zero SHALL be a match, not an error.
REQ-021 wordcnt and errcnt SHALL saturate at 2^CW-1, never wrap.
REQ-022 err, errcnt, wordcnt, halted SHALL be registered, updating one cycle after the accepting edge.
REQ-023 rdrdy SHALL be 0 in the cycle clr is high; clr wins over a simultaneous beat (beat not accepted).
REQ-024 rdrdy SHALL not depend combinationally on rdvld.
REQ-025 Without backpressure feature, rdrdy = 1 in SEED and CHECK.

Reset
REQ-026 rst low SHALL asynchronously force state=SEED, exp=0, err=0, errcnt=0, wordcnt=0, halted=0, rdrdy=0.
REQ-027 Reset deassertion mid-stream SHALL restart in SEED; first beat after reset is a seed, never an error.
REQ-028 LFSR (when compiled in) SHALL reset to 16'hACE1.

Configuration
REQ-029 Macro POWLIB_STRMCHK_BP_EN SHALL enable pseudo-random backpressure.
REQ-030 With macro: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle out of reset; rdrdy forced 0 when lfsr[1:0]==2'b00 (~25% of cycles), else per REQ-023/019/025.
REQ-031 Without macro: no LFSR logic present; rdrdy per REQ-019/023/025 only.

Structure
REQ-032 Shared package powlib_strmchk_pkg SHALL hold state encodings (SEED=2'd0, CHECK=2'd1, HALT=2'd2), LFSR seed and tap constants.
REQ-033 LFSR SHALL be sub-module powlib_lfsr (parameters width, taps, seed; ports clk, rst, en, state).
REQ-034 Implementation SHALL be a single always-block state machine plus registered counters; no memories.

Verification
REQ-035 Reset, then beats 5,6,7,8 -> wordcnt=4, errcnt=0, err=0, halted=0.
REQ-036 STOP_ON_ERR=0, beats 10,11,20,21 -> errcnt=1, err=1 one cycle after 20 accepted, wordcnt=4, no further errors.
REQ-037 STOP_ON_ERR=1, beats 1,2,9,10 -> HALT after 9, halted=1, rdrdy=0, beat 10 never accepted, wordcnt=3; clr -> SEED, counters 0, rdrdy=1.
REQ-038 W=8, beats 8'hFE,8'hFF,8'h00,8'h01 -> errcnt=0, wordcnt=4.
REQ-039 rst asserted after 3 beats, released, beats 100,101 -> wordcnt=2, errcnt=0.
REQ-040 POWLIB_STRMCHK_BP_EN defined, rdvld held 1 with incrementing data for 1000 cycles -> rdrdy low in 200-300 cycles, errcnt=0, wordcnt equals count of rdrdy-high cycles.
